// File: rtl/ram_dump_arbiter.sv
// Shares the single-port data RAM between the CPU and an end-of-run dump
// sequencer that streams words 0..DUMP_WORDS-1 to the UART, high byte first.
module ram_dump_arbiter #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int DUMP_WORDS  = 64,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_done,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic                  cpu_conflict
);
  // One extra counter bit so a full-RAM dump never wraps before the compare.
  localparam int              CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   LAST_IDX  = CW'(DUMP_WORDS - 1);
  localparam logic [1:0]      WAIT_INIT = 2'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND_HI, SEND_LO, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [1:0]             wait_q;
  logic [DATA_WIDTH-1:0]  word_q;
  logic [7:0]             tx_data_q;
  logic                   done_q, tx_valid_q, busy_q, dump_done_q, conflict_q;
  logic                   trigger, xfer;

  assign trigger      = cpu_done & ~done_q;
  assign xfer         = tx_valid_q & tx_ready;
  assign cpu_rdata    = ram_rdata;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign dump_busy    = busy_q;
  assign dump_done    = dump_done_q;
  assign cpu_conflict = conflict_q;

  // CPU owns the RAM only outside the dump; its accesses are dropped otherwise.
  always_comb begin
    if (state_q == IDLE || state_q == DONE) begin
      ram_we    = cpu_we;
      ram_re    = cpu_re;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else begin
      ram_we    = 1'b0;
      ram_re    = (state_q == READ);
      ram_addr  = cnt_q[ADDR_WIDTH-1:0];
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      word_q      <= '0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      dump_done_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      done_q <= cpu_done;
      if (busy_q && (cpu_we || cpu_re)) conflict_q <= 1'b1;
      case (state_q)
        IDLE: if (trigger) begin
          state_q <= READ;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        READ: begin
          state_q <= WAIT;
          wait_q  <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_q == 2'd0) begin
            word_q     <= ram_rdata;
            tx_data_q  <= ram_rdata[15:8];
            tx_valid_q <= 1'b1;
            state_q    <= SEND_HI;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        SEND_HI: if (xfer) begin
          tx_data_q <= word_q[7:0];
          state_q   <= SEND_LO;
        end
        SEND_LO: if (xfer) begin
          tx_valid_q <= 1'b0;
          if (cnt_q == LAST_IDX) begin
            busy_q      <= 1'b0;
            dump_done_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= READ;
          end
        end
        DONE: if (!cpu_done) begin
          dump_done_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_dump_arbiter.sv
// Directed bench: a 4-word dump instance for protocol tests and a 64-word
// instance for the full-RAM boundary, each with a 1-cycle RAM model.
module tb_ram_dump_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: 4 words ----------------
  logic        cd_a = 0, we_a = 0, re_a = 0, rdy_a = 1;
  logic [5:0]  addr_a = 0;
  logic [15:0] wd_a = 0, crd_a, rwd_a, rrd_a;
  logic        rwe_a, rre_a, txv_a, busy_a, dn_a, cf_a;
  logic [5:0]  raddr_a;
  logic [7:0]  txd_a;
  logic [15:0] mem_a [64];

  ram_dump_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .DUMP_WORDS(4), .RAM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .cpu_done(cd_a), .cpu_we(we_a), .cpu_re(re_a),
    .cpu_addr(addr_a), .cpu_wdata(wd_a), .cpu_rdata(crd_a), .ram_we(rwe_a),
    .ram_re(rre_a), .ram_addr(raddr_a), .ram_wdata(rwd_a), .ram_rdata(rrd_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a), .dump_busy(busy_a),
    .dump_done(dn_a), .cpu_conflict(cf_a));

  always @(posedge clk) begin
    if (rwe_a) mem_a[raddr_a] <= rwd_a;
    if (rre_a) rrd_a <= mem_a[raddr_a];
  end

  logic [7:0] bytes_a [$];
  logic [5:0] addrs_a [$];
  always @(posedge clk) if (reset) begin
    if (txv_a && rdy_a) bytes_a.push_back(txd_a);
    if (rre_a && busy_a) addrs_a.push_back(raddr_a);
  end

  // ---------------- instance B: 64 words ----------------
  logic        cd_b = 0, we_b = 0;
  logic [5:0]  addr_b = 0;
  logic [15:0] wd_b = 0, crd_b, rwd_b, rrd_b;
  logic        rwe_b, rre_b, txv_b, busy_b, dn_b, cf_b;
  logic [5:0]  raddr_b;
  logic [7:0]  txd_b;
  logic [15:0] mem_b [64];

  ram_dump_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .DUMP_WORDS(64), .RAM_LATENCY(1)) u_b (
    .clk(clk), .reset(reset), .cpu_done(cd_b), .cpu_we(we_b), .cpu_re(1'b0),
    .cpu_addr(addr_b), .cpu_wdata(wd_b), .cpu_rdata(crd_b), .ram_we(rwe_b),
    .ram_re(rre_b), .ram_addr(raddr_b), .ram_wdata(rwd_b), .ram_rdata(rrd_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(1'b1), .dump_busy(busy_b),
    .dump_done(dn_b), .cpu_conflict(cf_b));

  always @(posedge clk) begin
    if (rwe_b) mem_b[raddr_b] <= rwd_b;
    if (rre_b) rrd_b <= mem_b[raddr_b];
  end

  logic [7:0] bytes_b [$];
  logic [5:0] addrs_b [$];
  always @(posedge clk) if (reset) begin
    if (txv_b) bytes_b.push_back(txd_b);
    if (rre_b && busy_b) addrs_b.push_back(raddr_b);
  end

  task automatic cpu_wr_a(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk); we_a = 1; addr_a = a; wd_a = d;
    #1 chk("passthru_we", {rwe_a, raddr_a, rwd_a}, {1'b1, a, d});
    @(negedge clk); we_a = 0;
  endtask

  task automatic wait_done_a(input int lim);
    int n = 0;
    while (!dn_a && n < lim) begin @(negedge clk); n++; end
    chk("done_timeout_a", dn_a, 1);
  endtask

  task automatic retrigger_a;
    cd_a = 0; @(negedge clk);
    chk("done_clear", dn_a, 0);
    bytes_a.delete(); addrs_a.delete();
    cd_a = 1;
  endtask

  localparam logic [7:0] EXP_A [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF};

  initial begin
    int n;
    // reset values
    we_a = 1; addr_a = 6'd9; wd_a = 16'h0BAD;
    #1;
    chk("rst_outs", {txv_a, busy_a, dn_a, cf_a, txd_a}, 12'h0);
    chk("rst_mux", {rwe_a, raddr_a, rwd_a}, {1'b1, 6'd9, 16'h0BAD});
    we_a = 0;
    repeat (2) @(negedge clk);
    reset = 1;

    cpu_wr_a(0, 16'h1234); cpu_wr_a(1, 16'hABCD);
    cpu_wr_a(2, 16'h0000); cpu_wr_a(3, 16'hFFFF);
    cpu_wr_a(5, 16'h5555);
    @(negedge clk); re_a = 1; addr_a = 1;
    @(negedge clk); re_a = 0;
    chk("cpu_rdata", crd_a, 16'hABCD);

    // full dump
    cd_a = 1; n = 0;
    while (!busy_a && n < 20) begin @(negedge clk); n++; end
    chk("busy_rise", busy_a, 1);
    n = 0;
    while (!dn_a && n < 100) begin @(negedge clk); n++; end
    chk("done_latency", n, 16);
    chk("busy_after_done", busy_a, 0);
    chk("nbytes", bytes_a.size(), 8);
    for (int i = 0; i < 8; i++) if (i < bytes_a.size()) chk($sformatf("byte%0d", i), bytes_a[i], EXP_A[i]);
    chk("naddrs", addrs_a.size(), 4);
    for (int i = 0; i < 4; i++) if (i < addrs_a.size()) chk($sformatf("addr%0d", i), addrs_a[i], i);

    // held cpu_done: no second dump
    repeat (20) @(negedge clk);
    chk("hold_nobytes", bytes_a.size(), 8);
    chk("hold_state", {dn_a, busy_a}, 2'b10);

    // backpressure on first high byte
    rdy_a = 0;
    retrigger_a();
    n = 0;
    while (!txv_a && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {txv_a, txd_a}, {1'b1, 8'h12});
      @(negedge clk);
    end
    chk("bp_none_sent", bytes_a.size(), 0);
    rdy_a = 1;
    @(negedge clk);
    chk("bp_lo", {txv_a, txd_a}, {1'b1, 8'h34});
    wait_done_a(100);
    chk("bp_nbytes", bytes_a.size(), 8);
    if (addrs_a.size() > 0) chk("bp_addr0", addrs_a[0], 0);
    else chk("bp_addr0", addrs_a.size(), 1);

    // CPU write during WAIT is dropped
    retrigger_a();
    n = 0;
    while (!(rre_a && busy_a) && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    we_a = 1; addr_a = 5; wd_a = 16'hDEAD;
    #1 chk("conf_we_blocked", rwe_a, 0);
    @(negedge clk); we_a = 0;
    chk("conf_set", cf_a, 1);
    wait_done_a(100);
    chk("conf_sticky", cf_a, 1);
    chk("conf_mem5", mem_a[5], 16'h5555);

    // async reset during stalled SEND_HI
    rdy_a = 0;
    retrigger_a();
    n = 0;
    while (!txv_a && n < 20) begin @(negedge clk); n++; end
    chk("pre_rst_valid", txv_a, 1);
    #2 reset = 0;
    #1 chk("mid_rst", {txv_a, busy_a, dn_a, cf_a, txd_a}, 12'h0);
    cd_a = 0; rdy_a = 1;
    @(negedge clk); reset = 1;
    cpu_wr_a(7, 16'h0777);

    // full-RAM boundary on instance B
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); we_b = 1; addr_b = 6'(i); wd_b = 16'(i * 257);
    end
    @(negedge clk); we_b = 0; cd_b = 1;
    n = 0;
    while (!dn_b && n < 400) begin @(negedge clk); n++; end
    chk("b_done", dn_b, 1);
    chk("b_nbytes", bytes_b.size(), 128);
    for (int i = 0; i < 128; i++) if (i < bytes_b.size()) chk($sformatf("b_byte%0d", i), bytes_b[i], i / 2);
    chk("b_naddrs", addrs_b.size(), 64);
    for (int i = 0; i < 64; i++) if (i < addrs_b.size()) chk($sformatf("b_addr%0d", i), addrs_b[i], i);
    repeat (10) @(negedge clk);
    chk("b_no_wrap", {addrs_b.size(), bytes_b.size(), dn_b}, {32'd64, 32'd128, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ram_dump_arbiter.md
Name: ram_dump_arbiter

Overview:
- Owns the single-port data RAM and shares it between the CPU core and an end-of-run dump sequencer.
- While the program runs, CPU memory operations pass straight through to the RAM.
- When the CPU's end-of-execution flag rises, the block takes the RAM, reads words 0..DUMP_WORDS-1, and streams each word to the UART transmitter as two bytes, high byte first, over a valid/ready handshake.
- Sits between the CPU top, the RAM and the UART TX.

Parameters:
- ADDR_WIDTH, 6, RAM address width.
- DATA_WIDTH, 16, RAM word width. Fixed at 16 so each word splits into two bytes.
- DUMP_WORDS, 64, number of words dumped. Legal range 1..2^ADDR_WIDTH.
- RAM_LATENCY, 1, cycles from the clock edge that samples ram_re until ram_rdata is valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_done  in  1  CPU end-of-execution level.
- cpu_we  in  1  CPU RAM write enable.
- cpu_re  in  1  CPU RAM read enable.
- cpu_addr  in  ADDR_WIDTH  CPU RAM address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  read data returned to the CPU.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte.
- dump_busy  out  1  sequencer owns the RAM.
- dump_done  out  1  dump complete.
- cpu_conflict  out  1  sticky flag: CPU accessed RAM during a dump.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; address/word counter=0; word register=0; done_q=0.
  - tx_valid=0, tx_data=0, dump_busy=0, dump_done=0, cpu_conflict=0.
  - RAM outputs follow the IDLE mux rule below.
- Reset deassertion is synchronised by the system. A reset taken mid-dump abandons the dump; no partial byte is held.
- cpu_rdata = ram_rdata at all times (combinational).
- RAM mux:
  - In IDLE and DONE: ram_we/ram_re/ram_addr/ram_wdata = cpu_* (combinational).
  - In all other states: ram_we=0, ram_wdata=0, ram_addr=dump counter, ram_re=1 in READ only.
- Start trigger:
  - done_q registers cpu_done every cycle.
  - Trigger = cpu_done & ~done_q, sampled in IDLE.
  - A level held high since reset release counts as a rising edge on the first cycle after reset.
- States:
  - IDLE: on trigger go to READ, set counter=0, dump_busy=1.
  - READ (1 cycle): ram_re=1, ram_addr=counter. Go to WAIT.
  - WAIT (RAM_LATENCY cycles, internal down-counter): on the last WAIT edge, capture ram_rdata into the word register. Go to SEND_HI.
  - SEND_HI: tx_valid=1, tx_data=word[15:8]. The transfer happens on an edge where tx_valid&tx_ready=1; then go to SEND_LO.
  - SEND_LO: tx_valid=1, tx_data=word[7:0]. On transfer:
    - if counter==DUMP_WORDS-1, go to DONE;
    - else counter+1 and go to READ.
  - DONE: dump_busy=0, dump_done=1. Stay until cpu_done=0, then go to IDLE with dump_done=0. The counter is not reused.
- Handshake rules:
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer, except on reset.
  - tx_valid=0 in READ and WAIT.
  - tx_ready is ignored when tx_valid=0.
- Timing:
  - Throughput with tx_ready tied high is 3+RAM_LATENCY cycles per word.
  - Trigger sampled at edge k: READ in cycle k+1; first tx_valid in cycle k+2+RAM_LATENCY.
- Counter width is ADDR_WIDTH+1, so DUMP_WORDS=2^ADDR_WIDTH does not wrap. The last-word comparison is exact.
- CPU during dump: cpu_we or cpu_re asserted while dump_busy=1 sets cpu_conflict=1. The access is dropped (never reaches the RAM). cpu_conflict clears only on reset.
- A cpu_done rising edge while not in IDLE is ignored; there is no retrigger during a dump.
- A cpu_done fall during a dump does not abort it. DONE then exits on its next cycle.

Test Plan:
- Reset mid-everything: drive reset=0 during SEND_HI with tx_ready=0 -> tx_valid=0, dump_busy=0, dump_done=0, cpu_conflict=0 immediately (asynchronously). After release, CPU writes pass through to ram_we/ram_addr.
- Full dump, DUMP_WORDS=4, RAM_LATENCY=1, tx_ready=1, RAM preloaded 0x1234, 0xABCD, 0x0000, 0xFFFF:
  - raise cpu_done -> bytes 12, 34, AB, CD, 00, 00, FF, FF in order;
  - ram_addr 0..3 each with one ram_re pulse;
  - dump_done rises 16 cycles after READ is first entered.
- Backpressure: tx_ready=0 for 5 cycles during SEND_HI of word 0x1234 -> tx_data holds 0x12 with tx_valid=1 for all 5 cycles; the 0x34 byte follows only after the accepting edge.
- CPU conflict: assert cpu_we=1, cpu_addr=5, cpu_wdata=0xDEAD during WAIT -> ram_we stays 0, RAM[5] is unchanged, cpu_conflict=1 and stays 1 after DONE.
- Retrigger rules: hold cpu_done=1 after DONE -> no second dump. Drop cpu_done for 1 cycle then raise it -> dump_done clears and a new dump starts from address 0.
- Boundary: DUMP_WORDS=64 with an incrementing RAM pattern -> 128 bytes sent, last ram_addr=63, no wrap to 0, dump_done=1.
